// File: rtl/mul_iter_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encodings and
// the issue-to-done latency the hazard unit stalls on.
package mul_iter_unit_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StRun  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } mul_state_e;

  // Cycles from the start-sampling cycle to the done pulse.
  localparam int unsigned MUL_LATENCY = 35;

endpackage

// File: rtl/adder_32bits.sv
// Plain 32-bit unsigned adder with carry-in and carry-out.
module adder_32bits (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] s_o,
  output logic        co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, ci_i};

endmodule

// File: rtl/mul_iter_unit.sv
// Multi-cycle MULT/MULTU unit: magnitudes are multiplied by shift-add through a
// shared 32-bit adder, then the sign is fixed up before writing HI/LO.
module mul_iter_unit
  import mul_iter_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  mul_state_e         state_q;
  logic [WIDTH-1:0]   a_q, b_q, m_q, p_hi_q, p_lo_q, hi_q, lo_q;
  logic               sgn_q, neg_q, busy_q, done_q;
  logic [CntW-1:0]    count_q;

  logic [WIDTH-1:0]   add_b, sum, a_abs, b_abs;
  logic               co;
  logic [2*WIDTH-1:0] prod, result;

  always_comb begin
    add_b  = p_lo_q[0] ? m_q : '0;
    // 0x80000000 negates to itself, which reads correctly as an unsigned magnitude.
    a_abs  = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs  = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    prod   = {p_hi_q, p_lo_q};
    result = neg_q ? -prod : prod;
  end

  adder_32bits u_adder (
    .a_i  (p_hi_q),
    .b_i  (add_b),
    .ci_i (1'b0),
    .s_o  (sum),
    .co_o (co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      m_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sgn_q   <= is_signed;
            busy_q  <= 1'b1;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          neg_q   <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          m_q     <= a_abs;
          p_lo_q  <= b_abs;
          p_hi_q  <= '0;
          count_q <= '0;
          state_q <= StRun;
        end
        StRun: begin
          // 65-bit logical right shift of {carry, sum, multiplier}.
          p_hi_q  <= {co, sum[WIDTH-1:1]};
          p_lo_q  <= {sum[0], p_lo_q[WIDTH-1:1]};
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          {hi_q, lo_q} <= result;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed and random bench for mul_iter_unit using an expected-result queue.
module tb_mul_iter_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, busy, done;
  logic [31:0] a, b, hi, lo;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  int          done_cnt = 0;

  mul_iter_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] golden(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Presents start for one cycle (cycle T) and leaves the bench in cycle T+1.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp);
    is_signed = s;
    a         = x;
    b         = y;
    start     = 1'b1;
    exp_q.push_back(exp);
    accepted++;
    tick();
    start = 1'b0;
  endtask

  // Waits for done within a bounded budget, then checks latency and the result.
  task automatic wait_done(input string tag, input int exp_n);
    int          n;
    logic [63:0] e;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk({tag, "_hilo"}, {hi, lo}, e);
    chk({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int saved;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    // Basic MULTU with cycle-accurate busy/done.
    issue(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("t1_busy_T%0d", k), {63'b0, busy}, 64'd1);
      chk($sformatf("t1_nodone_T%0d", k), {63'b0, done}, 64'd0);
      tick();
    end
    wait_done("t1", 0);
    tick();
    chk("t1_done_pulse", {63'b0, done}, 64'd0);

    // Signed mixes and boundary operands.
    issue(1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("t2_neg3x7", 34);
    tick();
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_done("t2_m1xm1", 34);
    tick();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("t3_umax", 34);
    tick();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done("t3_smin_sq", 34);
    tick();
    issue(1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    wait_done("t3_smin_x1", 34);
    tick();

    // Start while busy is ignored.
    issue(1'b0, 32'd1000, 32'd1000, golden(1'b0, 32'd1000, 32'd1000));
    repeat (9) tick();
    is_signed = 1'b1; a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4_busy_ign", 24);

    // Start in DONE ignored, start the next cycle accepted.
    is_signed = 1'b0; a = 32'd2; b = 32'd2; start = 1'b1;
    tick();
    issue(1'b0, 32'h1234_5678, 32'h10, golden(1'b0, 32'h1234_5678, 32'h10));
    chk("t4_accept_busy", {63'b0, busy}, 64'd1);
    wait_done("t4_done_ign", 34);
    tick();

    // Operand changes after the start cycle have no effect.
    issue(1'b1, 32'hFFFF_0000, 32'h0001_0000, 64'hFFFF_FFFF_0000_0000);
    a = 32'd5; b = 32'd5; is_signed = 1'b0;
    wait_done("t4_opchg", 34);
    tick();

    // Synchronous reset mid-run aborts with no done pulse.
    issue(1'b0, 32'd100, 32'd100, golden(1'b0, 32'd100, 32'd100));
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", {63'b0, busy}, 64'd0);
    chk("t5_done", {63'b0, done}, 64'd0);
    chk("t5_hilo", {hi, lo}, 64'd0);
    void'(exp_q.pop_front());
    accepted--;
    saved = done_cnt;
    repeat (40) tick();
    chk("t5_no_done", 64'(done_cnt), 64'(saved));
    issue(1'b1, 32'hFFFF_FF00, 32'd3, golden(1'b1, 32'hFFFF_FF00, 32'd3));
    wait_done("t5_after", 34);
    tick();

    // Random back-to-back at the maximum issue rate.
    for (int i = 0; i < 200; i++) begin
      logic        s;
      logic [31:0] x, y;
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      issue(s, x, y, golden(s, x, y));
      wait_done($sformatf("rnd%0d", i), 34);
      tick();
    end

    chk("done_count", 64'(done_cnt), 64'(accepted));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
